// File: rtl/sseg_capture.sv
// sseg_capture: receives the multiplexed 7-segment digit bus, decodes the scanned
// hundreds/tens/ones digits back to BCD and reports the 9-bit binary value they show.
module sseg_capture #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sseg_indicator,
    input  logic [3:0] digits,
    output logic [8:0] address_value,
    output logic       value_valid,
    output logic       decode_error,
    output logic       link_lost
);

    localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 2);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(SETTLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_HIT  = TMO_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] SEG_IDLE = 8'hC0;
    localparam logic [3:0] DIG_IDLE = 4'b1111;

    localparam logic [2:0] S_WAIT_H  = 3'd0;
    localparam logic [2:0] S_WAIT_T  = 3'd1;
    localparam logic [2:0] S_WAIT_O  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    logic [7:0]        r_seg_m, r_seg_s;
    logic [3:0]        r_dig_m, r_dig_s;
    logic [11:0]       r_prev;
    logic [11:0]       w_cur;
    logic [STAB_W-1:0] r_stab;
    logic              w_capture;

    logic [3:0]        w_bcd;
    logic              w_seg_ok;
    logic              w_sel_h, w_sel_t, w_sel_o, w_sel_blank, w_sel_ok;
    logic              w_cap_ok, w_cap_err;

    logic [TMO_W-1:0]  r_tmo, w_tmo_nx;
    logic              r_lost;

    logic [2:0]        r_state, w_state_nx;
    logic [3:0]        r_h, r_t, r_o, w_h_nx, w_t_nx, w_o_nx;
    logic [8:0]        r_addr, w_addr_nx;
    logic              r_valid, w_valid_nx;
    logic              r_err, w_err_nx;
    logic [9:0]        w_sum;

    // Two-flop synchronizer for the segment and select lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg_m <= SEG_IDLE;
            r_seg_s <= SEG_IDLE;
            r_dig_m <= DIG_IDLE;
            r_dig_s <= DIG_IDLE;
        end else begin
            r_seg_m <= sseg_indicator;
            r_seg_s <= r_seg_m;
            r_dig_m <= digits;
            r_dig_s <= r_dig_m;
        end
    end

    assign w_cur = {r_seg_s, r_dig_s};

    // Stability counter: saturates one past the hit value so each stable period captures once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= {SEG_IDLE, DIG_IDLE};
            r_stab <= '0;
        end else begin
            r_prev <= w_cur;
            if (w_cur != r_prev) begin
                r_stab <= '0;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= r_stab + STAB_W'(1);
            end
        end
    end

    assign w_capture = (r_stab == STAB_HIT);

    // Segment pattern to BCD; the decimal point is ignored
    always_comb begin
        w_bcd    = 4'd0;
        w_seg_ok = 1'b1;
        case (r_seg_s[6:0])
            7'h40:   w_bcd = 4'd0;
            7'h79:   w_bcd = 4'd1;
            7'h24:   w_bcd = 4'd2;
            7'h30:   w_bcd = 4'd3;
            7'h19:   w_bcd = 4'd4;
            7'h12:   w_bcd = 4'd5;
            7'h02:   w_bcd = 4'd6;
            7'h78:   w_bcd = 4'd7;
            7'h00:   w_bcd = 4'd8;
            7'h10:   w_bcd = 4'd9;
            default: w_seg_ok = 1'b0;
        endcase
    end

    // Digit select decode
    always_comb begin
        w_sel_h     = 1'b0;
        w_sel_t     = 1'b0;
        w_sel_o     = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_ok    = 1'b1;
        case (r_dig_s)
            4'b1011: w_sel_h     = 1'b1;
            4'b1101: w_sel_t     = 1'b1;
            4'b1110: w_sel_o     = 1'b1;
            4'b1111: w_sel_blank = 1'b1;
            default: w_sel_ok    = 1'b0;
        endcase
    end

    assign w_cap_ok  = w_capture && w_sel_ok && !w_sel_blank && w_seg_ok;
    assign w_cap_err = w_capture && (!w_sel_ok || (!w_sel_blank && !w_seg_ok));

    // Link watchdog: counts cycles since the last legal capture
    assign w_tmo_nx = w_cap_ok ? '0 :
                      ((r_tmo == TMO_HIT) ? r_tmo : r_tmo + TMO_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo  <= '0;
            r_lost <= 1'b0;
        end else begin
            r_tmo  <= w_tmo_nx;
            r_lost <= (w_tmo_nx == TMO_HIT);
        end
    end

    assign w_sum = 10'(r_h) * 10'd100 + 10'(r_t) * 10'd10 + 10'(r_o);

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT_H;
            r_h     <= 4'd0;
            r_t     <= 4'd0;
            r_o     <= 4'd0;
            r_addr  <= 9'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_h     <= w_h_nx;
            r_t     <= w_t_nx;
            r_o     <= w_o_nx;
            r_addr  <= w_addr_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
        end
    end

    // Frame assembly: errors win over restarts, a lost link parks the frame in WAIT_H
    always_comb begin
        w_state_nx = r_state;
        w_h_nx     = r_h;
        w_t_nx     = r_t;
        w_o_nx     = r_o;
        w_addr_nx  = r_addr;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        if (w_cap_err || ((r_state == S_CONVERT) && (w_sum > 10'd511))) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_WAIT_H;
            w_h_nx     = 4'd0;
            w_t_nx     = 4'd0;
            w_o_nx     = 4'd0;
        end else if (r_lost && !w_cap_ok) begin
            w_state_nx = S_WAIT_H;
            w_h_nx     = 4'd0;
            w_t_nx     = 4'd0;
            w_o_nx     = 4'd0;
        end else begin
            case (r_state)
                S_WAIT_H: begin
                    if (w_cap_ok && w_sel_h) begin
                        w_h_nx     = w_bcd;
                        w_state_nx = S_WAIT_T;
                    end
                end
                S_WAIT_T: begin
                    if (w_cap_ok && w_sel_h) begin
                        w_h_nx = w_bcd;
                    end else if (w_cap_ok && w_sel_t) begin
                        w_t_nx     = w_bcd;
                        w_state_nx = S_WAIT_O;
                    end else if (w_cap_ok && w_sel_o) begin
                        w_h_nx     = 4'd0;
                        w_t_nx     = 4'd0;
                        w_state_nx = S_WAIT_H;
                    end
                end
                S_WAIT_O: begin
                    if (w_cap_ok && w_sel_o) begin
                        w_o_nx     = w_bcd;
                        w_state_nx = S_CONVERT;
                    end else if (w_cap_ok && w_sel_h) begin
                        w_h_nx     = w_bcd;
                        w_t_nx     = 4'd0;
                        w_state_nx = S_WAIT_T;
                    end else if (w_cap_ok && w_sel_t) begin
                        w_h_nx     = 4'd0;
                        w_t_nx     = 4'd0;
                        w_state_nx = S_WAIT_H;
                    end
                end
                S_CONVERT: begin
                    w_addr_nx  = w_sum[8:0];
                    w_valid_nx = 1'b1;
                    w_state_nx = S_REPORT;
                end
                S_REPORT: begin
                    w_state_nx = S_WAIT_H;
                end
                default: begin
                    w_state_nx = S_WAIT_H;
                end
            endcase
        end
    end

    assign address_value = r_addr;
    assign value_valid   = r_valid;
    assign decode_error  = r_err;
    assign link_lost     = r_lost;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: frames, range error, bad pattern, glitch, timeout, reset.
module tb_sseg_capture;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sseg  = 8'hC0;
    logic [3:0] dig   = 4'b1111;
    logic [8:0] address_value;
    logic       value_valid;
    logic       decode_error;
    logic       link_lost;

    int cyc            = 0;
    int n_valid        = 0;
    int n_err          = 0;
    int last_valid_cyc = 0;
    int last_chg       = 0;
    int n_chk          = 0;
    int n_pass         = 0;

    sseg_capture #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sseg_indicator (sseg),
        .digits         (dig),
        .address_value  (address_value),
        .value_valid    (value_valid),
        .decode_error   (decode_error),
        .link_lost      (link_lost)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (value_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (decode_error) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one digit/pattern pair for n cycles
    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        @(posedge clk);
        #1;
        dig      = d;
        sseg     = s;
        last_chg = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int v0, e0, t_ones;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",  int'(address_value), 0);
        check("rst_valid", int'(value_valid),   0);
        check("rst_err",   int'(decode_error),  0);
        check("rst_lost",  int'(link_lost),     0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Frame 3,5,9 -> 359
        v0 = n_valid; e0 = n_err;
        hold(4'b1011, 8'hB0, 100);
        hold(4'b1101, 8'h92, 100);
        hold(4'b1110, 8'h90, 100);
        t_ones = last_chg;
        #1;
        check("f359_addr",    int'(address_value), 359);
        check("f359_valid",   n_valid - v0, 1);
        check("f359_latency", last_valid_cyc - t_ones, 9);
        check("f359_err",     n_err - e0, 0);

        // Frame 5,1,2 -> 512 is out of range
        v0 = n_valid; e0 = n_err;
        hold(4'b1011, 8'h92, 100);
        hold(4'b1101, 8'hF9, 100);
        hold(4'b1110, 8'hA4, 100);
        #1;
        check("f512_err",   n_err - e0, 1);
        check("f512_valid", n_valid - v0, 0);
        check("f512_addr",  int'(address_value), 359);

        // Bad tens pattern, then the ones digit is dropped, then 0,0,7
        v0 = n_valid; e0 = n_err;
        hold(4'b1011, 8'hC0, 100);
        hold(4'b1101, 8'hFF, 100);
        #1;
        check("bad_err", n_err - e0, 1);
        hold(4'b1110, 8'hF8, 100);
        #1;
        check("bad_ones_err",   n_err - e0, 1);
        check("bad_ones_valid", n_valid - v0, 0);
        hold(4'b1011, 8'hC0, 100);
        hold(4'b1101, 8'hC0, 100);
        hold(4'b1110, 8'hF8, 100);
        #1;
        check("f007_addr",  int'(address_value), 7);
        check("f007_valid", n_valid - v0, 1);

        // Two-cycle glitch of pattern 80 at the start of the tens slot -> 123
        v0 = n_valid; e0 = n_err;
        hold(4'b1011, 8'hF9, 100);
        hold(4'b1101, 8'h80, 2);
        hold(4'b1101, 8'hA4, 100);
        hold(4'b1110, 8'hB0, 100);
        t_ones = last_chg;
        #1;
        check("f123_addr",  int'(address_value), 123);
        check("f123_valid", n_valid - v0, 1);
        check("f123_err",   n_err - e0, 0);

        // Illegal select raises an error and does not count as a capture
        e0 = n_err;
        hold(4'b0011, 8'hC0, 100);
        #1;
        check("sel_err", n_err - e0, 1);

        // Timeout: last legal capture was 7 cycles after the ones change
        hold(4'b1111, 8'hC0, 1);
        wait_cyc(t_ones + 1000);
        #1;
        check("tmo_before", int'(link_lost), 0);
        wait_cyc(t_ones + 1015);
        #1;
        check("tmo_after", int'(link_lost), 1);
        hold(4'b1011, 8'hC0, 20);
        #1;
        check("tmo_clear", int'(link_lost), 0);

        // Reset in the middle of a frame
        hold(4'b1011, 8'hF9, 100);
        hold(4'b1101, 8'hA4, 100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_addr",  int'(address_value), 0);
        check("mid_rst_valid", int'(value_valid),   0);
        check("mid_rst_err",   int'(decode_error),  0);
        check("mid_rst_lost",  int'(link_lost),     0);
        dig  = 4'b1110;
        sseg = 8'hB0;
        repeat (3) @(posedge clk);
        #1;
        v0 = n_valid; e0 = n_err;
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_valid", n_valid - v0, 0);
        check("post_rst_addr",  int'(address_value), 0);
        check("post_rst_err",   n_err - e0, 0);
        hold(4'b1011, 8'hA4, 100);
        hold(4'b1101, 8'h92, 100);
        hold(4'b1110, 8'h92, 100);
        #1;
        check("f255_addr",  int'(address_value), 255);
        check("f255_valid", n_valid - v0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
